// File: rtl/ball_motion_sequencer.sv
// Frame-rate motion sequencer for two bouncing 128x128 ball sprites.
// Each v_sync fall starts one pass that updates x0, y0, x1, y1 in turn through a single shared adder.
module ball_motion_sequencer #(
   parameter int SCREEN_WIDTH  = 800,
   parameter int SCREEN_HEIGHT = 600,
   parameter int START_X0      = 224,
   parameter int START_Y0      = 157,
   parameter int START_X1      = 425,
   parameter int START_Y1      = 188
) (
   input  logic       clk_50mhz,
   input  logic       reset,
   input  logic       v_sync,
   input  logic       enable,
   output logic [9:0] ball0_x,
   output logic [9:0] ball0_y,
   output logic [9:0] ball1_x,
   output logic [9:0] ball1_y,
   output logic       busy,
   output logic       frame_done
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] UPD_X0 = 3'd1;
   localparam logic [2:0] UPD_Y0 = 3'd2;
   localparam logic [2:0] UPD_X1 = 3'd3;
   localparam logic [2:0] UPD_Y1 = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;

   // Velocity flips direction around the screen centre minus half a sprite.
   localparam logic [9:0] HALF_X = 10'((SCREEN_WIDTH  - 128) / 2);
   localparam logic [9:0] HALF_Y = 10'((SCREEN_HEIGHT - 128) / 2);

   logic [2:0] state;
   logic       v_sync_d;
   logic [9:0] vel_x0;
   logic [9:0] vel_y0;
   logic [9:0] vel_x1;
   logic [9:0] vel_y1;

   logic       trigger;
   logic [9:0] sel_pos;
   logic [9:0] sel_vel;
   logic [9:0] sel_half;
   logic [9:0] step;
   logic [9:0] next_pos;
   logic [9:0] next_vel;

   assign trigger = v_sync_d & ~v_sync & enable;
   assign busy    = (state != IDLE);

   // NOTE: every output of this block gets a default first, so no latch is inferred on idle states.
   always_comb begin
      sel_pos  = ball0_x;
      sel_vel  = vel_x0;
      sel_half = HALF_X;
      case (state)
         UPD_Y0: begin
            sel_pos  = ball0_y;
            sel_vel  = vel_y0;
            sel_half = HALF_Y;
         end
         UPD_X1: begin
            sel_pos  = ball1_x;
            sel_vel  = vel_x1;
            sel_half = HALF_X;
         end
         UPD_Y1: begin
            sel_pos  = ball1_y;
            sel_vel  = vel_y1;
            sel_half = HALF_Y;
         end
         default: ;
      endcase
   end

   // Shared datapath: quarter-rate signed step, unsigned compare against the axis midpoint.
   assign step     = {{2{sel_vel[9]}}, sel_vel[9:2]};
   assign next_pos = sel_pos + step;
   assign next_vel = (next_pos < sel_half) ? sel_vel + 10'd1 : sel_vel - 10'd1;

   // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk_50mhz) begin
      if (reset) begin
         state      <= IDLE;
         v_sync_d   <= 1'b0;
         ball0_x    <= 10'(START_X0);
         ball0_y    <= 10'(START_Y0);
         ball1_x    <= 10'(START_X1);
         ball1_y    <= 10'(START_Y1);
         vel_x0     <= '0;
         vel_y0     <= '0;
         vel_x1     <= '0;
         vel_y1     <= '0;
         frame_done <= 1'b0;
      end else begin
         v_sync_d   <= v_sync;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (trigger) state <= UPD_X0;
            end
            UPD_X0: begin
               ball0_x <= next_pos;
               vel_x0  <= next_vel;
               state   <= UPD_Y0;
            end
            UPD_Y0: begin
               ball0_y <= next_pos;
               vel_y0  <= next_vel;
               state   <= UPD_X1;
            end
            UPD_X1: begin
               ball1_x <= next_pos;
               vel_x1  <= next_vel;
               state   <= UPD_Y1;
            end
            UPD_Y1: begin
               ball1_y    <= next_pos;
               vel_y1     <= next_vel;
               frame_done <= 1'b1;
               state      <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/ball_motion_sequencer.md
BALL_MOTION_SEQUENCER -- requirements
Module: ball_motion_sequencer

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 800, visible width in pixels.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 600, visible height in lines.
REQ-003 SHALL have parameters START_X0=224, START_Y0=157, START_X1=425, START_Y1=188, the reset positions of ball 0 and ball 1.
REQ-004 SHALL have port clk_50mhz, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-006 SHALL have port v_sync, input, 1 bit, active-low vertical sync from the vga timing block, same clock domain.
REQ-007 SHALL have port enable, input, 1 bit; 1 permits frame updates.
REQ-008 SHALL have ports ball0_x, ball0_y, ball1_x, ball1_y, outputs, 10 bits each, the current top-left corner of each 128x128 ball sprite.
REQ-009 SHALL have port busy, output, 1 bit, high while an update sequence is in progress.
REQ-010 SHALL have port frame_done, output, 1 bit, a one-cycle pulse when a sequence completes.

Function
REQ-011 SHALL register v_sync into v_sync_d each cycle.
REQ-012 SHALL define a frame trigger as v_sync_d==1 and v_sync==0 and enable==1, sampled at clock edge k.
REQ-013 SHALL use states IDLE, UPD_X0, UPD_Y0, UPD_X1, UPD_Y1 and DONE.
REQ-014 Transitions: IDLE goes to UPD_X0 on a trigger at edge k; each UPD_* state lasts exactly one cycle, in the order X0, Y0, X1, Y1, DONE; DONE returns to IDLE after one cycle.
REQ-015 SHALL time the ball 0 updates so that x/vx change at edge k+1 and y/vy change at edge k+2.
REQ-016 SHALL time the ball 1 updates so that x/vx change at edge k+3 and y/vy change at edge k+4.
REQ-017 SHALL drive frame_done high from edge k+4 to edge k+5 only.
REQ-018 SHALL drive busy high from edge k to edge k+5.
REQ-019 SHALL share one adder and one comparator across all four axis updates; at most one axis updates per cycle.
REQ-020 Axis update, 10-bit wrap-around arithmetic: n = p + sign_extend(v[9:2]); p <= n.
REQ-021 Velocity update: v <= v + 1 if n < (LIMIT-128)/2, else v <= v - 1. LIMIT is SCREEN_WIDTH for x and SCREEN_HEIGHT for y, and the comparison is unsigned.
REQ-022 Velocity overflow SHALL wrap modulo 2^10 with no saturation.
REQ-023 SHALL ignore triggers while busy; a held-low v_sync SHALL produce exactly one sequence.
REQ-024 SHALL ignore the enable level once a sequence has started; deasserting enable mid-sequence SHALL NOT abort it.
REQ-025 With enable low, positions and velocities SHALL hold and frame_done SHALL stay 0.
REQ-026 Position outputs SHALL be driven directly from their registers, with no combinational path from any input.

Reset
REQ-027 On reset: state=IDLE, ball positions = START_* parameters, all velocities=0, v_sync_d=0, busy=0, frame_done=0.
REQ-028 Reset SHALL take priority over every other event, including a trigger in the same cycle.
REQ-029 Reset mid-sequence SHALL discard partial updates and restore REQ-027 values at the next edge.
REQ-030 Because v_sync_d resets to 0, a v_sync that is low at reset release SHALL NOT trigger until it has been seen high and then low.

Verification
REQ-031 First frame after reset: v_sync 1 then 0, enable=1 -> ball0 stays (224,157) with vx=1, vy=1; ball1 stays (425,188) with vx=10'h3FF, vy=1; frame_done pulses at k+4.
REQ-032 Second frame: ball0_x=224 with vx=2; ball1_x=424 with vx=10'h3FE; ball0_y=157 with vy=2; ball1_y=188 with vy=2.
REQ-033 v_sync held low 1000 cycles -> exactly one frame_done pulse; busy high for exactly 5 cycles.
REQ-034 enable=0 across 3 v_sync falls -> outputs remain 224/157/425/188; frame_done never asserted.
REQ-035 reset asserted at edge k+2 -> next cycle outputs = start values, busy=0; no frame_done pulse.
REQ-036 Preload vx=10'h1FF, then run 1 frame with n<336 -> vx=10'h200 (wrap); x advances by 10'h07F (+127).
